// File: rtl/disp_axi_pkg.sv
// Shared AXI read-side constants and types for the display VRAM slave.
package disp_axi_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // One beat is 8 bytes, so the word address starts at byte-address bit 3.
  localparam int BEAT_BYTES = 8;
  localparam int BEAT_SHIFT = 3;

  localparam logic [1:0] ST_IDLE_OH  = 2'b01;
  localparam logic [1:0] ST_BURST_OH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE_OH,
    S_BURST = ST_BURST_OH
  } state_t;

  function automatic logic [1:0] beat_resp(input logic err);
    return err ? RRESP_DECERR : RRESP_OKAY;
  endfunction

endpackage

// File: rtl/disp_rskid2.sv
// Two-entry FIFO holding returned beats as {data, last, resp}.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module disp_rskid2 #(
  parameter int W = 67
) (
  input  logic         ACLK,
  input  logic         ARST,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_ent [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_ent[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_ent[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/disp_vram_rdslave.sv
// AXI4 INCR read responder backed by a 1-cycle synchronous RAM.
// One burst outstanding; fetches are throttled so that at most two words
// are ever owed to the master (buffered plus in flight from the RAM).
//
// state   | meaning
// S_IDLE  | ARREADY high, waiting for an address
// S_BURST | fetching and returning beats until the RLAST handshake
module disp_vram_rdslave
  import disp_axi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 1
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic              MEM_RE,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam int ENT_W = DATA_W + 3;

  state_t            r_state;
  logic              r_arready;
  logic [MEM_AW-1:0] r_addr;
  logic [8:0]        r_fetch_rem;
  logic              r_err;
  logic              r_inflight;
  logic              r_inf_last;
  logic              r_inf_err;

  logic [2:0]        w_occ;
  logic              w_fetch;
  logic [DATA_W-1:0] w_in_data;
  logic              w_in_last;
  logic [1:0]        w_in_resp;
  logic [ENT_W-1:0]  w_in_ent;
  logic [ENT_W-1:0]  w_fifo_dout;
  logic [ENT_W-1:0]  w_head;
  logic [1:0]        w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_rhs;
  logic              w_unused;

  // Byte offset is ignored; the full flag is redundant with the count-based throttle.
  assign w_unused = ^{ARADDR[2:0], w_fifo_full};

  // Words owed to the master must stay within the RAM pipeline depth plus one.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight};
  assign w_fetch = !ARST && (r_state == S_BURST) && (r_fetch_rem != 9'd0)
                   && (w_occ < 3'(RD_LAT + 1));

  // Decode-error bursts run the same fetch cadence but never touch the RAM.
  assign MEM_RE   = w_fetch && !r_err;
  assign MEM_ADDR = r_addr;

  assign w_in_data = (r_inflight && !r_inf_err) ? MEM_RDATA : '0;
  assign w_in_last = r_inflight && r_inf_last;
  assign w_in_resp = r_inflight ? beat_resp(r_inf_err) : RRESP_OKAY;
  assign w_in_ent  = {w_in_data, w_in_last, w_in_resp};

  // Returning word bypasses an empty FIFO so RVALID follows MEM_RE by one cycle;
  // it is buffered only if it cannot be handed over immediately.
  assign RVALID = !w_fifo_empty || r_inflight;
  assign w_head = w_fifo_empty ? w_in_ent : w_fifo_dout;
  assign RDATA  = w_head[ENT_W-1:3];
  assign RLAST  = w_head[2];
  assign RRESP  = w_head[1:0];

  assign w_rhs  = RVALID && RREADY;
  assign w_push = r_inflight && !(w_fifo_empty && RREADY);
  assign w_pop  = w_rhs && !w_fifo_empty;

  assign ARREADY = r_arready && !ARST;

  disp_rskid2 #(.W(ENT_W)) u_rskid (
    .ACLK    (ACLK),
    .ARST    (ARST),
    .i_push  (w_push),
    .i_din   (w_in_ent),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Burst FSM, fetch address/down-counter and in-flight tracking.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_state     <= S_IDLE;
      r_arready   <= 1'b1;
      r_addr      <= '0;
      r_fetch_rem <= 9'd0;
      r_err       <= 1'b0;
      r_inflight  <= 1'b0;
      r_inf_last  <= 1'b0;
      r_inf_err   <= 1'b0;
    end else begin
      r_inflight <= w_fetch;
      r_inf_last <= w_fetch && (r_fetch_rem == 9'd1);
      r_inf_err  <= w_fetch && r_err;
      if (w_fetch) begin
        r_addr      <= r_addr + 1'b1;
        r_fetch_rem <= r_fetch_rem - 9'd1;
      end
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b1;
          if (ARVALID && r_arready) begin
            r_addr      <= ARADDR[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
            r_fetch_rem <= {1'b0, ARLEN} + 9'd1;
            r_err       <= |ARADDR[31:MEM_AW+BEAT_SHIFT];
            r_arready   <= 1'b0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_rhs && RLAST) begin
            r_arready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_arready <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
